slc3_ctrl_seq: RTL and testbench

// Parametrised SLC-3 instruction sequencer/decoder (control FSM). Drives all datapath load/gate/mux

---
 rtl/slc3_ctrl_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 tb/tb_slc3_ctrl_seq.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slc3_ctrl_seq.sv
// -----------------------------------------------------------------------------
// slc3_ctrl_seq
// SLC-3 instruction sequencer / control decoder. A single FSM walks every
// instruction through FETCH -> MEMRD -> IRLD -> DECODE -> execute states and
// drives the datapath load, bus-gate and mux selects plus the BRAM Mem_OE and
// Mem_WE strobes.
//
// Memory wait states are produced by one shared read state (MEMRD) and one
// shared write state (MEMWR). Each is held for a parameterised number of
// cycles by the wait counter wcnt_r. A return tag (ret_r) tells MEMRD where to
// go once the read completes: IRLD, LDR_WB or IND_MAR.
//
// Parameters
//   RD_WAIT     cycles Mem_OE is held per read, LD.MDR on the last (1..15)
//   WR_WAIT     cycles Mem_WE+Mem_OE are held per write (1..15)
//   EN_INDIRECT 1: decode LDI/STI/LEA, 0: those opcodes behave as NOPs
//
// Ports
//   Clk        in   clock, rising edge
//   Reset      in   synchronous active-high reset
//   Run        in   leaves HALTED (ignored elsewhere)
//   Continue   in   PAUSE release handshake
//   Opcode     in   IR[15:12]
//   IR_5       in   imm5/register select for ADD/AND
//   IR_11      in   JSR(1)/JSRR(0) select
//   BEN        in   latched branch enable
//   LD         out  {LED,PC,REG,CC,BEN,IR,MDR,MAR} loads
//   GATE       out  {MARMUX,ALU,MDR,PC} bus drivers (one-hot or zero)
//   PCMUX      out  00 bus, 01 address adder, 10 PC+1
//   DRMUX      out  0 R7, 1 IR[11:9]
//   SR1MUX     out  0 IR[11:9], 1 IR[8:6]
//   SR2MUX     out  0 sext imm5, 1 SR2 register
//   ADDR1MUX   out  0 SR1, 1 PC
//   ADDR2MUX   out  00 off11, 01 off9, 10 off6, 11 zero
//   ALUK       out  00 ADD, 01 AND, 10 NOT, 11 PASS A
//   Mem_OE     out  BRAM enable
//   Mem_WE     out  BRAM write enable
// -----------------------------------------------------------------------------
module slc3_ctrl_seq #(
    parameter int RD_WAIT     = 3,
    parameter int WR_WAIT     = 3,
    parameter bit EN_INDIRECT = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic [7:0] LD,
    output logic [3:0] GATE,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    // FSM state encoding
    localparam logic [4:0] S_HALTED   = 5'd0;
    localparam logic [4:0] S_FETCH    = 5'd1;
    localparam logic [4:0] S_MEMRD    = 5'd2;
    localparam logic [4:0] S_IRLD     = 5'd3;
    localparam logic [4:0] S_DECODE   = 5'd4;
    localparam logic [4:0] S_ADD      = 5'd5;
    localparam logic [4:0] S_AND      = 5'd6;
    localparam logic [4:0] S_NOT      = 5'd7;
    localparam logic [4:0] S_LDR      = 5'd8;
    localparam logic [4:0] S_LDR_WB   = 5'd9;
    localparam logic [4:0] S_STR      = 5'd10;
    localparam logic [4:0] S_ST_MDR   = 5'd11;
    localparam logic [4:0] S_MEMWR    = 5'd12;
    localparam logic [4:0] S_IND_ADDR = 5'd13;
    localparam logic [4:0] S_IND_MAR  = 5'd14;
    localparam logic [4:0] S_LEA      = 5'd15;
    localparam logic [4:0] S_JSR_R7   = 5'd16;
    localparam logic [4:0] S_JSR_PC   = 5'd17;
    localparam logic [4:0] S_JMP      = 5'd18;
    localparam logic [4:0] S_BR       = 5'd19;
    localparam logic [4:0] S_PAUSE1   = 5'd20;
    localparam logic [4:0] S_PAUSE2   = 5'd21;

    // Where MEMRD goes once the read completes
    localparam logic [1:0] RET_IR      = 2'd0;
    localparam logic [1:0] RET_LDR_WB  = 2'd1;
    localparam logic [1:0] RET_IND_MAR = 2'd2;

    // Opcodes
    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_LDI   = 4'b1010;
    localparam logic [3:0] OP_STI   = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;
    localparam logic [3:0] OP_LEA   = 4'b1110;

    // LD / GATE bit masks
    localparam logic [7:0] LD_LED = 8'h80;
    localparam logic [7:0] LD_PC  = 8'h40;
    localparam logic [7:0] LD_REG = 8'h20;
    localparam logic [7:0] LD_CC  = 8'h10;
    localparam logic [7:0] LD_BEN = 8'h08;
    localparam logic [7:0] LD_IR  = 8'h04;
    localparam logic [7:0] LD_MDR = 8'h02;
    localparam logic [7:0] LD_MAR = 8'h01;

    localparam logic [3:0] G_MARMUX = 4'b1000;
    localparam logic [3:0] G_ALU    = 4'b0100;
    localparam logic [3:0] G_MDR    = 4'b0010;
    localparam logic [3:0] G_PC     = 4'b0001;

    // Last count value of each wait window
    localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LAST = 4'(WR_WAIT - 1);

    logic [4:0] state_r;
    logic [4:0] state_nxt_s;
    logic [3:0] wcnt_r;
    logic [3:0] wcnt_nxt_s;
    logic [1:0] ret_r;
    logic [1:0] ret_nxt_s;

    // Next-state, wait-counter and return-tag logic
    always_comb begin
        state_nxt_s = state_r;
        wcnt_nxt_s  = 4'd0;
        ret_nxt_s   = ret_r;
        case (state_r)
            S_HALTED: begin
                if (Run) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_HALTED;
                end
            end
            S_FETCH: begin
                state_nxt_s = S_MEMRD;
                ret_nxt_s   = RET_IR;
            end
            S_MEMRD: begin
                if (wcnt_r == RD_LAST) begin
                    case (ret_r)
                        RET_IR:      state_nxt_s = S_IRLD;
                        RET_LDR_WB:  state_nxt_s = S_LDR_WB;
                        RET_IND_MAR: state_nxt_s = S_IND_MAR;
                        default:     state_nxt_s = S_FETCH;
                    endcase
                end else begin
                    wcnt_nxt_s = wcnt_r + 4'd1;
                end
            end
            S_IRLD: state_nxt_s = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_ADD:   state_nxt_s = S_ADD;
                    OP_AND:   state_nxt_s = S_AND;
                    OP_NOT:   state_nxt_s = S_NOT;
                    OP_LDR:   state_nxt_s = S_LDR;
                    OP_STR:   state_nxt_s = S_STR;
                    OP_JSR:   state_nxt_s = S_JSR_R7;
                    OP_JMP:   state_nxt_s = S_JMP;
                    OP_PAUSE: state_nxt_s = S_PAUSE1;
                    OP_BR:    state_nxt_s = BEN ? S_BR : S_FETCH;
                    OP_LDI:   state_nxt_s = EN_INDIRECT ? S_IND_ADDR : S_FETCH;
                    OP_STI:   state_nxt_s = EN_INDIRECT ? S_IND_ADDR : S_FETCH;
                    OP_LEA:   state_nxt_s = EN_INDIRECT ? S_LEA : S_FETCH;
                    default:  state_nxt_s = S_FETCH;
                endcase
            end
            S_LDR: begin
                state_nxt_s = S_MEMRD;
                ret_nxt_s   = RET_LDR_WB;
            end
            S_STR:    state_nxt_s = S_ST_MDR;
            S_ST_MDR: state_nxt_s = S_MEMWR;
            S_MEMWR: begin
                if (wcnt_r == WR_LAST) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    wcnt_nxt_s = wcnt_r + 4'd1;
                end
            end
            S_IND_ADDR: begin
                state_nxt_s = S_MEMRD;
                ret_nxt_s   = RET_IND_MAR;
            end
            S_IND_MAR: begin
                // MAR now holds the pointer: STI writes through it, LDI reads it
                if (Opcode == OP_STI) begin
                    state_nxt_s = S_ST_MDR;
                end else begin
                    state_nxt_s = S_MEMRD;
                    ret_nxt_s   = RET_LDR_WB;
                end
            end
            S_JSR_R7: state_nxt_s = S_JSR_PC;
            S_PAUSE1: begin
                if (Continue) begin
                    state_nxt_s = S_PAUSE2;
                end else begin
                    state_nxt_s = S_PAUSE1;
                end
            end
            S_PAUSE2: begin
                if (!Continue) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_PAUSE2;
                end
            end
            S_ADD, S_AND, S_NOT, S_LDR_WB, S_LEA, S_JSR_PC, S_JMP, S_BR:
                state_nxt_s = S_FETCH;
            default: state_nxt_s = S_HALTED;
        endcase
    end

    // State, wait counter and return tag registers; Reset wins over everything
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= S_HALTED;
            wcnt_r  <= 4'd0;
            ret_r   <= RET_IR;
        end else begin
            state_r <= state_nxt_s;
            wcnt_r  <= wcnt_nxt_s;
            ret_r   <= ret_nxt_s;
        end
    end

    // Output decode from the registered state (IR_5 / IR_11 pass through live)
    always_comb begin
        LD       = 8'h00;
        GATE     = 4'h0;
        PCMUX    = 2'b10;
        DRMUX    = 1'b0;
        SR1MUX   = 1'b0;
        SR2MUX   = 1'b0;
        ADDR1MUX = 1'b0;
        ADDR2MUX = 2'b00;
        ALUK     = 2'b00;
        Mem_OE   = 1'b0;
        Mem_WE   = 1'b0;
        case (state_r)
            S_FETCH: begin
                GATE = G_PC;
                LD   = LD_MAR | LD_PC;
            end
            S_MEMRD: begin
                Mem_OE = 1'b1;
                LD     = (wcnt_r == RD_LAST) ? LD_MDR : 8'h00;
            end
            S_IRLD: begin
                GATE = G_MDR;
                LD   = LD_IR;
            end
            S_DECODE: LD = LD_BEN;
            S_ADD, S_AND, S_NOT: begin
                DRMUX  = 1'b1;
                SR1MUX = 1'b1;
                GATE   = G_ALU;
                LD     = LD_REG | LD_CC;
                if (state_r == S_ADD) begin
                    ALUK   = 2'b00;
                    SR2MUX = IR_5;
                end else if (state_r == S_AND) begin
                    ALUK   = 2'b01;
                    SR2MUX = IR_5;
                end else begin
                    ALUK   = 2'b10;
                    SR2MUX = 1'b0;
                end
            end
            S_LDR, S_STR: begin
                // Base register lives in IR[8:6]
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b0;
                ADDR2MUX = 2'b10;
                GATE     = G_MARMUX;
                LD       = LD_MAR;
            end
            S_LDR_WB: begin
                GATE  = G_MDR;
                DRMUX = 1'b1;
                LD    = LD_REG | LD_CC;
            end
            S_ST_MDR: begin
                SR1MUX = 1'b0;
                ALUK   = 2'b11;
                GATE   = G_ALU;
                LD     = LD_MDR;
            end
            S_MEMWR: begin
                Mem_OE = 1'b1;
                Mem_WE = 1'b1;
            end
            S_IND_ADDR: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = 2'b01;
                GATE     = G_MARMUX;
                LD       = LD_MAR;
            end
            S_IND_MAR: begin
                GATE = G_MDR;
                LD   = LD_MAR;
            end
            S_LEA: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = 2'b01;
                GATE     = G_MARMUX;
                DRMUX    = 1'b1;
                LD       = LD_REG;
            end
            S_JSR_R7: begin
                GATE  = G_PC;
                DRMUX = 1'b0;
                LD    = LD_REG;
            end
            S_JSR_PC: begin
                LD = LD_PC;
                if (IR_11) begin
                    ADDR1MUX = 1'b1;
                    ADDR2MUX = 2'b00;
                    PCMUX    = 2'b01;
                end else begin
                    SR1MUX = 1'b1;
                    ALUK   = 2'b11;
                    GATE   = G_ALU;
                    PCMUX  = 2'b00;
                end
            end
            S_JMP: begin
                SR1MUX = 1'b1;
                ALUK   = 2'b11;
                GATE   = G_ALU;
                PCMUX  = 2'b00;
                LD     = LD_PC;
            end
            S_BR: begin
                ADDR1MUX = 1'b1;
                ADDR2MUX = 2'b01;
                PCMUX    = 2'b01;
                LD       = LD_PC;
            end
            S_PAUSE1, S_PAUSE2: LD = LD_LED;
            default: LD = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_slc3_ctrl_seq.sv
// Directed bench for slc3_ctrl_seq. dut0 uses default parameters and is
// checked cycle by cycle from a vector table; dut1 (RD_WAIT=5, WR_WAIT=2,
// EN_INDIRECT=0) is checked with hand-written multi-cycle sequences.
// Both instances share the same input stimulus.
module tb_slc3_ctrl_seq;

    logic       Clk;
    logic       Reset;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;

    logic [7:0] LD0, LD1;
    logic [3:0] GATE0, GATE1;
    logic [1:0] PCMUX0, PCMUX1, ADDR2MUX0, ADDR2MUX1, ALUK0, ALUK1;
    logic       DRMUX0, DRMUX1, SR1MUX0, SR1MUX1, SR2MUX0, SR2MUX1;
    logic       ADDR1MUX0, ADDR1MUX1, Mem_OE0, Mem_OE1, Mem_WE0, Mem_WE1;

    slc3_ctrl_seq dut0 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD(LD0), .GATE(GATE0), .PCMUX(PCMUX0), .DRMUX(DRMUX0),
        .SR1MUX(SR1MUX0), .SR2MUX(SR2MUX0), .ADDR1MUX(ADDR1MUX0),
        .ADDR2MUX(ADDR2MUX0), .ALUK(ALUK0), .Mem_OE(Mem_OE0), .Mem_WE(Mem_WE0)
    );

    slc3_ctrl_seq #(.RD_WAIT(5), .WR_WAIT(2), .EN_INDIRECT(1'b0)) dut1 (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD(LD1), .GATE(GATE1), .PCMUX(PCMUX1), .DRMUX(DRMUX1),
        .SR1MUX(SR1MUX1), .SR2MUX(SR2MUX1), .ADDR1MUX(ADDR1MUX1),
        .ADDR2MUX(ADDR2MUX1), .ALUK(ALUK1), .Mem_OE(Mem_OE1), .Mem_WE(Mem_WE1)
    );

    // {LD, GATE, PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, OE, WE}
    logic [23:0] obs0, obs1;
    assign obs0 = {LD0, GATE0, PCMUX0, DRMUX0, SR1MUX0, SR2MUX0, ADDR1MUX0,
                   ADDR2MUX0, ALUK0, Mem_OE0, Mem_WE0};
    assign obs1 = {LD1, GATE1, PCMUX1, DRMUX1, SR1MUX1, SR2MUX1, ADDR1MUX1,
                   ADDR2MUX1, ALUK1, Mem_OE1, Mem_WE1};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        run;
        logic        cont;
        logic [3:0]  op;
        logic        ir5;
        logic        ir11;
        logic        ben;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    logic [23:0] IDLE, FETCH, MRD, MRD_L, IRLD, DEC, ADD1, AND0, NOTX;
    logic [23:0] LDR_A, LDR_WB, ST_MDR, MWR, JSR_R7, JSR_PC1, JSR_PC0;
    logic [23:0] JMP, BRX, LEA, IND_A, IND_MAR, PAUSE;

    function automatic logic [23:0] mk(input logic [7:0] ld, input logic [3:0] gt,
                                       input logic [1:0] pcm, input logic dr,
                                       input logic sr1, input logic sr2, input logic a1,
                                       input logic [1:0] a2, input logic [1:0] aluk,
                                       input logic oe, input logic we);
        return {ld, gt, pcm, dr, sr1, sr2, a1, a2, aluk, oe, we};
    endfunction

    task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input string nm, input logic rst, input logic run, input logic cont,
                        input logic [3:0] op, input logic ir5, input logic ir11,
                        input logic ben, input logic [23:0] e);
        vec_t v;
        v.name = nm; v.rst = rst; v.run = run; v.cont = cont;
        v.op = op; v.ir5 = ir5; v.ir11 = ir11; v.ben = ben; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic row(input string nm, input logic run, input logic [3:0] op,
                       input logic ir5, input logic ir11, input logic ben,
                       input logic [23:0] e);
        push(nm, 1'b0, run, 1'b0, op, ir5, ir11, ben, e);
    endtask

    // Instruction read (RD_WAIT=3), IR load and decode following a FETCH
    task automatic instr(input string nm, input logic run, input logic [3:0] op,
                         input logic ir5, input logic ir11, input logic ben);
        row({nm, "_rd0"}, run, op, ir5, ir11, ben, MRD);
        row({nm, "_rd1"}, run, op, ir5, ir11, ben, MRD);
        row({nm, "_rd2"}, run, op, ir5, ir11, ben, MRD_L);
        row({nm, "_irld"}, run, op, ir5, ir11, ben, IRLD);
        row({nm, "_dec"}, run, op, ir5, ir11, ben, DEC);
    endtask

    task automatic data_rd(input string nm, input logic [3:0] op);
        row({nm, "_drd0"}, 1'b0, op, 1'b0, 1'b0, 1'b0, MRD);
        row({nm, "_drd1"}, 1'b0, op, 1'b0, 1'b0, 1'b0, MRD);
        row({nm, "_drd2"}, 1'b0, op, 1'b0, 1'b0, 1'b0, MRD_L);
    endtask

    task automatic data_wr(input string nm, input logic [3:0] op);
        row({nm, "_wr0"}, 1'b0, op, 1'b0, 1'b0, 1'b0, MWR);
        row({nm, "_wr1"}, 1'b0, op, 1'b0, 1'b0, 1'b0, MWR);
        row({nm, "_wr2"}, 1'b0, op, 1'b0, 1'b0, 1'b0, MWR);
    endtask

    initial begin
        int oe_cnt;
        int mdr_cnt;
        int mdr_at;
        int we_cnt;
        int we_bad;
        int waited;
        bit seen;

        Reset = 1'b1; Run = 1'b0; Continue = 1'b0; Opcode = 4'h0;
        IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;

        IDLE    = mk(8'h00, 4'b0000, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        FETCH   = mk(8'h41, 4'b0001, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        MRD     = mk(8'h00, 4'b0000, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        MRD_L   = mk(8'h02, 4'b0000, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        IRLD    = mk(8'h04, 4'b0010, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        DEC     = mk(8'h08, 4'b0000, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        ADD1    = mk(8'h30, 4'b0100, 2'b10, 1, 1, 1, 0, 2'b00, 2'b00, 0, 0);
        AND0    = mk(8'h30, 4'b0100, 2'b10, 1, 1, 0, 0, 2'b00, 2'b01, 0, 0);
        NOTX    = mk(8'h30, 4'b0100, 2'b10, 1, 1, 0, 0, 2'b00, 2'b10, 0, 0);
        LDR_A   = mk(8'h01, 4'b1000, 2'b10, 0, 1, 0, 0, 2'b10, 2'b00, 0, 0);
        LDR_WB  = mk(8'h30, 4'b0010, 2'b10, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        ST_MDR  = mk(8'h02, 4'b0100, 2'b10, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0);
        MWR     = mk(8'h00, 4'b0000, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
        JSR_R7  = mk(8'h20, 4'b0001, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        JSR_PC1 = mk(8'h40, 4'b0000, 2'b01, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0);
        JSR_PC0 = mk(8'h40, 4'b0100, 2'b00, 0, 1, 0, 0, 2'b00, 2'b11, 0, 0);
        JMP     = mk(8'h40, 4'b0100, 2'b00, 0, 1, 0, 0, 2'b00, 2'b11, 0, 0);
        BRX     = mk(8'h40, 4'b0000, 2'b01, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0);
        LEA     = mk(8'h20, 4'b1000, 2'b10, 1, 0, 0, 1, 2'b01, 2'b00, 0, 0);
        IND_A   = mk(8'h01, 4'b1000, 2'b10, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0);
        IND_MAR = mk(8'h01, 4'b0010, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        PAUSE   = mk(8'h80, 4'b0000, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

        // ---------------- vector table for dut0 ----------------
        push("rst0", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, IDLE);
        push("rst1", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, IDLE);
        for (int i = 0; i < 20; i++) row("halted", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, IDLE);
        row("run_fetch", 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, FETCH);
        // ADD with Run still high: Run must have no effect outside HALTED
        instr("add", 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        row("add_ex", 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, ADD1);
        row("add_fetch", 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, FETCH);
        instr("and", 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0);
        row("and_ex", 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, AND0);
        row("and_fetch", 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, FETCH);
        instr("not", 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0);
        row("not_ex", 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0, NOTX);
        row("not_fetch", 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0, FETCH);
        instr("ldr", 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
        row("ldr_mar", 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, LDR_A);
        data_rd("ldr", 4'b0110);
        row("ldr_wb", 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, LDR_WB);
        row("ldr_fetch", 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, FETCH);
        instr("str", 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);
        row("str_mar", 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, LDR_A);
        row("str_mdr", 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, ST_MDR);
        data_wr("str", 4'b0111);
        row("str_fetch", 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, FETCH);
        instr("jsr", 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0);
        row("jsr_r7", 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, JSR_R7);
        row("jsr_pc", 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, JSR_PC1);
        row("jsr_fetch", 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, FETCH);
        instr("jsrr", 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
        row("jsrr_r7", 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, JSR_R7);
        row("jsrr_pc", 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, JSR_PC0);
        row("jsrr_fetch", 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, FETCH);
        instr("jmp", 1'b0, 4'b1100, 1'b0, 1'b0, 1'b0);
        row("jmp_ex", 1'b0, 4'b1100, 1'b0, 1'b0, 1'b0, JMP);
        row("jmp_fetch", 1'b0, 4'b1100, 1'b0, 1'b0, 1'b0, FETCH);
        instr("br1", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        row("br1_ex", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, BRX);
        row("br1_fetch", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, FETCH);
        instr("br0", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        row("br0_fetch", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, FETCH);
        instr("lea", 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0);
        row("lea_ex", 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, LEA);
        row("lea_fetch", 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, FETCH);
        instr("ldi", 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0);
        row("ldi_addr", 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, IND_A);
        data_rd("ldi_p", 4'b1010);
        row("ldi_mar", 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, IND_MAR);
        data_rd("ldi_d", 4'b1010);
        row("ldi_wb", 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, LDR_WB);
        row("ldi_fetch", 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0, FETCH);
        instr("sti", 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0);
        row("sti_addr", 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, IND_A);
        data_rd("sti_p", 4'b1011);
        row("sti_mar", 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, IND_MAR);
        row("sti_mdr", 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, ST_MDR);
        data_wr("sti", 4'b1011);
        row("sti_fetch", 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, FETCH);
        instr("trap", 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        row("trap_fetch", 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, FETCH);
        push("rst_mid", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, IDLE);
        row("halt_after_rst", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, IDLE);

        for (int i = 0; i < vecs.size(); i++) begin
            Reset = vecs[i].rst; Run = vecs[i].run; Continue = vecs[i].cont;
            Opcode = vecs[i].op; IR_5 = vecs[i].ir5; IR_11 = vecs[i].ir11;
            BEN = vecs[i].ben;
            tick();
            check(vecs[i].name, obs0, vecs[i].exp);
        end

        // ---------------- dut1: RD_WAIT=5, EN_INDIRECT=0 ----------------
        Reset = 1'b1; Run = 1'b0; Continue = 1'b0; Opcode = 4'b1010;
        IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
        tick(); tick();
        check("d1_rst", obs1, IDLE);
        Reset = 1'b0; Run = 1'b1;
        tick();
        check("d1_fetch", obs1, FETCH);
        Run = 1'b0;
        oe_cnt = 0; mdr_cnt = 0; mdr_at = 0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Mem_OE1) begin
                seen = 1'b1;
                oe_cnt++;
                if (LD1[1]) begin
                    mdr_cnt++;
                    mdr_at = oe_cnt;
                end
            end else if (seen) begin
                break;
            end
        end
        check_int("d1_oe_len", oe_cnt, 5);
        check_int("d1_mdr_count", mdr_cnt, 1);
        check_int("d1_mdr_pos", mdr_at, 5);
        check("d1_irld", obs1, IRLD);
        tick();
        check("d1_dec", obs1, DEC);
        tick();
        check("d1_ldi_nop_fetch", obs1, FETCH);

        // STR on dut1: WR_WAIT=2
        Opcode = 4'b0111;
        we_cnt = 0; we_bad = 0; seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (Mem_WE1) begin
                seen = 1'b1;
                we_cnt++;
                if (!Mem_OE1) we_bad++;
            end else if (seen) begin
                break;
            end
        end
        check_int("d1_we_len", we_cnt, 2);
        check_int("d1_we_without_oe", we_bad, 0);
        check("d1_str_fetch", obs1, FETCH);

        // Next STR: Reset asserted during the first write cycle
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (Mem_WE1) begin
                seen = 1'b1;
                break;
            end
        end
        check_int("d1_we_reached", int'(seen), 1);
        Reset = 1'b1;
        tick();
        check_int("d1_we_after_rst", int'(Mem_WE1), 0);
        check("d1_idle_after_rst", obs1, IDLE);
        Reset = 1'b0;
        tick(); tick(); tick();
        check("d1_stays_halted", obs1, IDLE);

        // PAUSE handshake on dut1
        Opcode = 4'b1101; Run = 1'b1;
        tick();
        check("d1_pause_fetch", obs1, FETCH);
        Run = 1'b0;
        waited = 0;
        while (obs1 !== PAUSE && waited < 20) begin
            tick();
            waited++;
        end
        check("d1_pause_enter", obs1, PAUSE);
        check_int("d1_pause_latency", waited, 8);
        for (int i = 0; i < 4; i++) tick();
        check("d1_pause_hold", obs1, PAUSE);
        Continue = 1'b1;
        tick();
        check("d1_pause2", obs1, PAUSE);
        tick(); tick();
        check("d1_pause2_hold", obs1, PAUSE);
        Continue = 1'b0;
        tick();
        check("d1_pause_release", obs1, FETCH);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
